// File: rtl/button_debounce.sv
// Multi-channel pad synchronizer and debouncer: two-flop sync, stability counter,
// registered rise/fall pulses and a press-toggle latch per channel.
module button_debounce #(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned STABLE_CYCLES = 240000,
    parameter bit          INVERT        = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] toggle_o
);

    localparam int unsigned    CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_lvl;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_tog;
    logic [CW-1:0]    r_cnt [WIDTH];

    assign w_in = raw_i ^ {WIDTH{INVERT}};

    // A channel accepts its synchronized value once it has differed from the
    // current level for STABLE_CYCLES consecutive edges.
    always_comb begin
        w_accept = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_accept[k] = (r_s2[k] != r_lvl[k]) && (r_cnt[k] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_lvl  <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_tog  <= '0;
            for (int unsigned k = 0; k < WIDTH; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_s1   <= w_in;
            r_s2   <= r_s1;
            r_lvl  <= r_lvl ^ w_accept;
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
            r_tog  <= r_tog ^ (w_accept & r_s2);
            for (int unsigned k = 0; k < WIDTH; k++) begin
                if ((r_s2[k] == r_lvl[k]) || w_accept[k]) begin
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
        end
    end

    assign level_o  = r_lvl;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign toggle_o = r_tog;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with WIDTH=2, STABLE_CYCLES=4; a second
// instance with INVERT=1 covers active-low pads.
module tb_button_debounce;

    logic       clk;
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] raw_inv;
    logic [1:0] level, rise, fall, tog;
    logic [1:0] level_n, rise_n, fall_n, tog_n;

    int n_tests;
    int n_fail;
    int rises;
    int falls;

    button_debounce #(.WIDTH(2), .STABLE_CYCLES(4), .INVERT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .raw_i(raw),
        .level_o(level), .rise_o(rise), .fall_o(fall), .toggle_o(tog)
    );

    button_debounce #(.WIDTH(2), .STABLE_CYCLES(4), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .raw_i(raw_inv),
        .level_o(level_n), .rise_o(rise_n), .fall_o(fall_n), .toggle_o(tog_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n active edges, then sample 1 ns later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " level"}, level, 2'b00);
        check({tag, " rise"}, rise, 2'b00);
        check({tag, " fall"}, fall, 2'b00);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        raw     = 2'b11;
        raw_inv = 2'b11;

        // Reset held with inputs asserted: everything stays 0.
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_idle("rst");
            check("rst tog", tog, 2'b00);
        end
        rst_n = 1'b1;
        raw   = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_idle("post-rst");
            check("post-rst inv level", level_n, 2'b00);
        end

        // Clean press and release on channel 0.
        raw = 2'b01;
        step(5);
        check("press e5 level", level, 2'b00);
        step(1);
        check("press e6 level", level, 2'b01);
        check("press e6 rise", rise, 2'b01);
        check("press e6 tog", tog, 2'b01);
        step(1);
        check("press e7 rise", rise, 2'b00);
        check("press e7 level", level, 2'b01);
        raw = 2'b00;
        step(5);
        check("rel e5 level", level, 2'b01);
        check("rel e5 fall", fall, 2'b00);
        step(1);
        check("rel e6 level", level, 2'b00);
        check("rel e6 fall", fall, 2'b01);
        check("rel e6 rise", rise, 2'b00);
        check("rel e6 tog", tog, 2'b01);
        step(1);
        check("rel e7 fall", fall, 2'b00);

        // Three-cycle glitch on channel 1 is rejected.
        raw = 2'b10;
        step(3);
        raw = 2'b00;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_idle("glitch3");
        end
        // Four cycles is just enough; the low that follows is accepted too.
        raw = 2'b10;
        step(4);
        raw = 2'b00;
        step(1);
        check("glitch4 e5 level", level, 2'b00);
        step(1);
        check("glitch4 e6 level", level, 2'b10);
        check("glitch4 e6 rise", rise, 2'b10);
        step(4);
        check("glitch4 e10 level", level, 2'b00);
        check("glitch4 e10 fall", fall, 2'b10);
        check("glitch4 tog", tog, 2'b11);

        // Bounce 1,0,1,0 then held 1: acceptance 6 edges after the final rise.
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            raw = (i % 2 == 0) ? 2'b01 : 2'b00;
            step(1);
            rises += int'(rise[0]);
        end
        raw = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            rises += int'(rise[0]);
        end
        check("bounce e5 level", level, 2'b00);
        step(1);
        rises += int'(rise[0]);
        check("bounce e6 level", level, 2'b01);
        check("bounce e6 rise", rise, 2'b01);
        for (int i = 0; i < 3; i++) begin
            step(1);
            rises += int'(rise[0]);
        end
        check("bounce rise count", rises, 1);
        check("bounce tog", tog, 2'b10);
        raw = 2'b00;
        step(8);
        check_idle("bounce settle");

        // Fresh reset, then two presses on channel 0 toggle it back to 0.
        rst_n = 1'b0;
        step(2);
        check("rst2 tog", tog, 2'b00);
        rst_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            raw = 2'b01;
            step(6);
            check("press2 level", level, 2'b01);
            check("press2 rise", rise, 2'b01);
            check("press2 tog", tog, (p == 0) ? 2'b01 : 2'b00);
            raw = 2'b00;
            falls = 0;
            for (int i = 0; i < 8; i++) begin
                step(1);
                falls += int'(fall[0]);
            end
            check("press2 fall count", falls, 1);
            check("press2 rel level", level, 2'b00);
        end

        // Both channels together.
        raw = 2'b11;
        step(5);
        check("simul e5 level", level, 2'b00);
        step(1);
        check("simul e6 level", level, 2'b11);
        check("simul e6 rise", rise, 2'b11);
        check("simul e6 tog", tog, 2'b11);
        raw = 2'b00;
        step(8);
        check_idle("simul settle");

        // Reset at edge 4 of a press discards progress.
        raw = 2'b01;
        step(3);
        rst_n = 1'b0;
        step(1);
        check_idle("midrst");
        check("midrst tog", tog, 2'b00);
        step(1);
        rst_n = 1'b1;
        step(5);
        check("midrst e5 level", level, 2'b00);
        step(1);
        check("midrst e6 level", level, 2'b01);
        check("midrst e6 rise", rise, 2'b01);

        // Inverted instance: idle high pads read as released; pulling bit 0 low presses.
        check("inv idle level", level_n, 2'b00);
        raw_inv = 2'b10;
        step(5);
        check("inv e5 level", level_n, 2'b00);
        step(1);
        check("inv e6 level", level_n, 2'b01);
        check("inv e6 rise", rise_n, 2'b01);
        check("inv e6 tog", tog_n, 2'b01);
        step(1);
        check("inv e7 rise", rise_n, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
